// File: rtl/count_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : count_arbiter
// Purpose  : Round-robin arbiter and sequencer for a shared WIDTH-bit up
//            counter used as an interval timer. One requester at a time is
//            granted the counter, which runs from 0 up to that requester's
//            latched terminal value. A one-cycle done pulse follows.
// Ports    : clk    - clock, rising edge active
//            reset  - asynchronous active-high reset
//            req    - level request, one bit per requester
//            len    - terminal count per requester, slice i = len[i*WIDTH +: WIDTH]
//            grant  - one-hot grant, zero when no interval is running
//            owner  - index of the current or most recent grantee
//            busy   - high whenever the sequencer is not idle
//            done   - one-cycle completion pulse to the owner
//            count  - live counter value
// Revision : 1.0 - initial release
// ============================================================================
module count_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     len,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [N_REQ-1:0]           done,
  output logic [WIDTH-1:0]           count
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   term_q;
  logic [WIDTH-1:0]   count_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic [OW-1:0]      owner_q;
  logic               busy_q;
  // Set until the first grant: the search must start at requester 0 rather
  // than owner+1, since owner also resets to 0.
  logic               first_q;

  logic               found_d;
  logic [OW-1:0]      sel_d;
  int unsigned        start_d;
  int unsigned        idx_d;

  // Circular priority search starting just above the most recent owner.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    idx_d   = 0;
    start_d = first_q ? 0 : (int'(owner_q) + 1) % N_REQ;
    for (int k = 0; k < N_REQ; k++) begin
      idx_d = (start_d + k) % N_REQ;
      if (!found_d && req[idx_d]) begin
        found_d = 1'b1;
        sel_d   = idx_d[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      term_q  <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (found_d) begin
            owner_q <= sel_d;
            term_q  <= len[sel_d*WIDTH +: WIDTH];
            count_q <= '0;
            grant_q <= N_REQ'(1) << sel_d;
            busy_q  <= 1'b1;
            first_q <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Terminal count is tested first so completion beats a
          // simultaneous request drop.
          if (count_q == term_q) begin
            done_q  <= grant_q;
            grant_q <= '0;
            state_q <= S_DONE;
          end else if (!req[owner_q]) begin
            grant_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end
        S_DONE: begin
          done_q  <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          grant_q <= '0;
          done_q  <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_arbiter
// Purpose  : Self-checking bench for count_arbiter. Directed scenarios plus
//            randomized requests, compared each cycle against a behavioural
//            interval-timer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_arbiter;

  localparam int WIDTH = 4;
  localparam int N_REQ = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   len;
  logic [N_REQ-1:0]         grant;
  logic [1:0]               owner;
  logic                     busy;
  logic [N_REQ-1:0]         done;
  logic [WIDTH-1:0]         count;

  count_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: an interval is either running (with owner, term and
  // elapsed count), finishing (done cycle), or absent.
  bit m_run, m_fin, m_first;
  int m_owner, m_term, m_count;

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_first = 1;
    m_owner = 0; m_term = 0; m_count = 0;
  endtask

  task automatic model_step();
    int start;
    bit found;
    if (m_fin) begin
      m_fin = 0;
      m_count = 0;
    end else if (m_run) begin
      if (m_count == m_term) begin
        m_run = 0;
        m_fin = 1;
      end else if (!req[m_owner]) begin
        m_run = 0;
        m_count = 0;
      end else begin
        m_count = m_count + 1;
      end
    end else begin
      start = m_first ? 0 : (m_owner + 1) % N_REQ;
      found = 0;
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (start + k) % N_REQ;
        if (!found && req[idx]) begin
          found   = 1;
          m_run   = 1;
          m_owner = idx;
          m_term  = int'(len[idx*WIDTH +: WIDTH]);
          m_count = 0;
          m_first = 0;
        end
      end
    end
  endtask

  task automatic compare();
    int eg, ed;
    eg = m_run ? (1 << m_owner) : 0;
    ed = m_fin ? (1 << m_owner) : 0;
    check("grant", 32'(grant), 32'(eg));
    check("done",  32'(done),  32'(ed));
    check("busy",  32'(busy),  32'(m_run || m_fin));
    check("count", 32'(count), 32'(m_count));
    check("owner", 32'(owner), 32'(m_owner));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic settle();
    req = '0;
    repeat (4) step();
  endtask

  task automatic run_until_count(input int v, input int budget);
    int n;
    n = 0;
    while (!(grant != 0 && int'(count) == v) && n < budget) begin
      step();
      n++;
    end
    check("wait_count", 32'(count), 32'(v));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int rr_own[$];
  int rr_cyc[$];

  initial begin
    reset = 1'b1;
    req   = '0;
    len   = '0;
    #12;
    do_reset();

    // Single request, len = 3
    len[0*WIDTH +: WIDTH] = 4'd3;
    req = 4'b0001;
    step();
    req = 4'b0000;
    repeat (6) step();

    // Round robin from reset, all len = 1
    do_reset();
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    begin
      logic [N_REQ-1:0] prev;
      prev = '0;
      for (int c = 0; c < 24; c++) begin
        step();
        if (grant != 0 && prev == 0) begin
          rr_own.push_back(int'(owner));
          rr_cyc.push_back(c);
        end
        prev = grant;
      end
    end
    if (rr_own.size() >= 5) begin
      check("rr_order0", 32'(rr_own[0]), 32'd0);
      check("rr_order1", 32'(rr_own[1]), 32'd1);
      check("rr_order2", 32'(rr_own[2]), 32'd2);
      check("rr_order3", 32'(rr_own[3]), 32'd3);
      check("rr_order4", 32'(rr_own[4]), 32'd0);
      check("rr_gap",    32'(rr_cyc[4] - rr_cyc[3]), 32'd4);
    end else begin
      check("rr_grants", 32'(rr_own.size()), 32'd5);
    end
    settle();

    // Abort: requester 2, len 9, dropped at count 4
    len[2*WIDTH +: WIDTH] = 4'd9;
    req = 4'b0100;
    run_until_count(4, 30);
    req = 4'b0000;
    step();
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_owner", 32'(owner), 32'd2);
    repeat (3) step();

    // len = 0: single RUN cycle then done
    len[0*WIDTH +: WIDTH] = 4'd0;
    req = 4'b0001;
    step();
    check("len0_grant", 32'(grant), 32'b0001);
    check("len0_count", 32'(count), 32'd0);
    req = 4'b0000;
    step();
    check("len0_done", 32'(done), 32'b0001);
    settle();

    // len = 15: reaches all-ones without wrapping
    len[0*WIDTH +: WIDTH] = 4'd15;
    req = 4'b0001;
    run_until_count(15, 40);
    req = 4'b0000;
    step();
    check("len15_done",  32'(done),  32'b0001);
    check("len15_count", 32'(count), 32'd15);
    settle();

    // Abort coinciding with terminal count: completion wins
    len[1*WIDTH +: WIDTH] = 4'd2;
    req = 4'b0010;
    run_until_count(2, 30);
    req = 4'b0000;
    step();
    check("coin_done", 32'(done), 32'b0010);
    settle();

    // Asynchronous reset mid-run, then priority restarts at requester 0
    len[3*WIDTH +: WIDTH] = 4'd9;
    req = 4'b1000;
    run_until_count(5, 30);
    do_reset();
    len[0*WIDTH +: WIDTH] = 4'd2;
    req = 4'b1001;
    step();
    check("post_rst_grant", 32'(grant), 32'b0001);
    settle();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 3) req[$urandom_range(0, N_REQ-1)] ^= 1'b1;
      r = int'($urandom_range(0, 7));
      len[$urandom_range(0, N_REQ-1)*WIDTH +: WIDTH] =
        (r == 0) ? 4'd15 : WIDTH'($urandom_range(0, 5));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
